// File: rtl/action_ram_arbiter.sv
// action_ram_arbiter: shares one sync-read 256x16 action RAM between two read
// requesters (rd0 move-lookup, rd1 AI policy) and one write requester.
// Optional feature macro: ACTION_ARB_RR_EN (round-robin between rd0/rd1);
// when undefined rd0 has fixed priority.
// Ports:
//   clock, reset_n              clock / asynchronous active-low reset
//   wr_req/wr_addr/wr_data      write request (held until wr_ack)
//   wr_ack                      one-cycle write-accept pulse
//   rdN_req/rdN_addr            read request (held until rdN_ack)
//   rdN_ack                     one-cycle grant pulse
//   rdN_valid/rdN_data          read-return pulse / data held until next valid
//   ram_write_enable/_address, ram_d_in, ram_read_address  to action_ram
//   ram_d_out                   from action_ram (1 cycle after read_address)
module action_ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_ack,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_ack,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_d_in,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic [DATA_W-1:0] ram_d_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} rd_state_t;

    rd_state_t         state_q, state_d;
    logic              owner_q;          // 1: in-flight read belongs to rd1
    logic              wr_accept_c;
    logic              pick0, pick1;
    logic              collide;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] cand_addr;

`ifdef ACTION_ARB_RR_EN
    logic              last_rd1_q;       // 1: rd1 was served last
`endif

    // A held write request is accepted only on the cycle after its ack drops.
    assign wr_accept_c = wr_req & ~wr_ack;

    // Arbitration, collision deferral and next-state logic.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
`ifdef ACTION_ARB_RR_EN
        if (rd0_req && rd1_req) begin
            pick0 = last_rd1_q;
            pick1 = ~last_rd1_q;
        end else begin
            pick0 = rd0_req;
            pick1 = rd1_req;
        end
`else
        pick0 = rd0_req;
        pick1 = rd1_req & ~rd0_req;
`endif
        cand_addr = pick1 ? rd1_addr : rd0_addr;
        // Same-address write in this edge: wait one cycle so the read sees new data.
        collide = wr_accept_c & (pick0 | pick1) & (cand_addr == wr_addr);
        case (state_q)
            IDLE: begin
                if ((pick0 || pick1) && !collide) begin
                    gnt0    = pick0;
                    gnt1    = pick1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Read-side registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd0_ack          <= 1'b0;
            rd1_ack          <= 1'b0;
            rd0_valid        <= 1'b0;
            rd1_valid        <= 1'b0;
            rd0_data         <= '0;
            rd1_data         <= '0;
            ram_read_address <= '0;
            owner_q          <= 1'b0;
        end else begin
            rd0_ack   <= gnt0;
            rd1_ack   <= gnt1;
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            if (gnt0 || gnt1) begin
                ram_read_address <= cand_addr;
                owner_q          <= gnt1;
            end
            if (state_q == CAPTURE) begin
                if (owner_q) begin
                    rd1_valid <= 1'b1;
                    rd1_data  <= ram_d_out;
                end else begin
                    rd0_valid <= 1'b1;
                    rd0_data  <= ram_d_out;
                end
            end
        end
    end

`ifdef ACTION_ARB_RR_EN
    // Round-robin pointer; reset to rd1 so rd0 wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          last_rd1_q <= 1'b1;
        else if (gnt0 || gnt1) last_rd1_q <= gnt1;
    end
`endif

    // Write path, independent of the read FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ack            <= 1'b0;
            ram_write_enable  <= 1'b0;
            ram_write_address <= '0;
            ram_d_in          <= '0;
        end else begin
            wr_ack           <= wr_accept_c;
            ram_write_enable <= wr_accept_c;
            if (wr_accept_c) begin
                ram_write_address <= wr_addr;
                ram_d_in          <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_action_ram_arbiter.sv
module tb_action_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        rd0_req = 1'b0, rd1_req = 1'b0;
    logic [7:0]  rd0_addr = '0, rd1_addr = '0;
    logic        rd0_ack, rd1_ack, rd0_valid, rd1_valid;
    logic [15:0] rd0_data, rd1_data;
    logic        ram_write_enable;
    logic [7:0]  ram_write_address, ram_read_address;
    logic [15:0] ram_d_in;
    logic [15:0] ram_d_out = '0;

    int checks = 0;
    int errors = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] mem [256];

    action_ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack),
        .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack),
        .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .ram_write_enable(ram_write_enable), .ram_write_address(ram_write_address),
        .ram_d_in(ram_d_in), .ram_read_address(ram_read_address), .ram_d_out(ram_d_out)
    );

    always #5 clock = ~clock;

    // Behavioural action RAM: sync read, read-before-write on the same edge.
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_d_in;
        ram_d_out <= mem[ram_read_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop expected read data on each valid pulse.
    always @(negedge clock) begin
        if (reset_n && rd0_valid) begin
            if (q0.size() == 0) chk("rd0_unexpected_valid", 32'(rd0_valid), 32'd0);
            else                chk("rd0_data", 32'(rd0_data), 32'(q0.pop_front()));
        end
        if (reset_n && rd1_valid) begin
            if (q1.size() == 0) chk("rd1_unexpected_valid", 32'(rd1_valid), 32'd0);
            else                chk("rd1_data", 32'(rd1_data), 32'(q1.pop_front()));
        end
    end

    task automatic step(output int n, input bit use_wr, input bit p);
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!(use_wr ? wr_ack : (p ? rd1_ack : rd0_ack)) && n < 20);
        if (n >= 20) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        int n;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        step(n, 1'b1, 1'b0);
        chk("wr_en_on_ack", 32'(ram_write_enable), 32'd1);
        chk("wr_addr_out", 32'(ram_write_address), 32'(a));
        chk("wr_data_out", 32'(ram_d_in), 32'(d));
        wr_req = 1'b0;
        @(posedge clock); #1;
        chk("wr_en_drop", 32'(ram_write_enable), 32'd0);
    endtask

    task automatic do_read(input bit p, input logic [7:0] a, input logic [15:0] e);
        int n;
        if (p) begin rd1_addr = a; rd1_req = 1'b1; q1.push_back(e); end
        else   begin rd0_addr = a; rd0_req = 1'b1; q0.push_back(e); end
        step(n, 1'b0, p);
        if (p) rd1_req = 1'b0; else rd0_req = 1'b0;
        @(posedge clock); #1;
        chk("valid_early", 32'(p ? rd1_valid : rd0_valid), 32'd0);
        @(posedge clock); #1;
        chk("valid_at_grant_plus2", 32'(p ? rd1_valid : rd0_valid), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        bit          port;
        logic [7:0]  addr;
        logic [15:0] data;   // write data or expected read data
    } vec_t;
    vec_t vecs [10];

    initial begin
        int n;
        bit exp_p;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        vecs[0] = '{1'b1, 1'b0, 8'h03, 16'h0005};
        vecs[1] = '{1'b0, 1'b0, 8'h03, 16'h0005};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 16'hFFFF};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 16'h1234};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 16'h0101};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 16'hFFFF};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 16'h1234};
        vecs[7] = '{1'b0, 1'b0, 8'h01, 16'h0101};
        vecs[8] = '{1'b0, 1'b1, 8'hFF, 16'hFFFF};
        vecs[9] = '{1'b0, 1'b1, 8'h03, 16'h0005};

        // Reset state
        #12;
        chk("reset_outputs_zero", 32'(|{wr_ack, rd0_ack, rd1_ack, rd0_valid, rd1_valid,
            rd0_data, rd1_data, ram_write_enable, ram_write_address, ram_d_in,
            ram_read_address}), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // Table-driven writes and reads, including the 8'hFF boundary
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].port, vecs[i].addr, vecs[i].data);
        end

        // Held write request advancing on ack: one accept every 2 cycles
        wr_addr = 8'h20; wr_data = 16'd2; wr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(n, 1'b1, 1'b0);
            if (i > 0) chk("wr_ack_spacing", 32'(n), 32'd2);
            chk("wr_seq_addr", 32'(ram_write_address), 32'(8'h20 + 8'(i)));
            if (i < 5) begin
                wr_addr = 8'h21 + 8'(i); wr_data = 16'd3 + 16'(i);
            end else wr_req = 1'b0;
        end
        @(posedge clock); #1;
        for (int i = 0; i < 6; i++) do_read(1'(i), 8'h20 + 8'(i), 16'd2 + 16'(i));

        // Collision: same-address write and rd1 read in the same cycle
        wr_addr = 8'h21; wr_data = 16'h00AA; wr_req = 1'b1;
        rd1_addr = 8'h21; rd1_req = 1'b1; q1.push_back(16'h00AA);
        @(posedge clock); #1;
        chk("coll_wr_ack", 32'(wr_ack), 32'd1);
        chk("coll_rd1_deferred", 32'(rd1_ack), 32'd0);
        wr_req = 1'b0;
        @(posedge clock); #1;
        chk("coll_rd1_ack_late", 32'(rd1_ack), 32'd1);
        rd1_req = 1'b0;
        repeat (3) @(posedge clock); #1;

        // Contention with both requests held
        rd0_addr = 8'h00; rd1_addr = 8'h01; rd0_req = 1'b1; rd1_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(posedge clock); #1; n++; end while (!(rd0_ack || rd1_ack) && n < 6);
            if (g > 0) chk("grant_spacing", 32'(n), 32'd3);
`ifdef ACTION_ARB_RR_EN
            exp_p = 1'(g);
`else
            exp_p = 1'b0;
`endif
            chk("grant_rd1", 32'(rd1_ack), 32'(exp_p));
            chk("grant_rd0", 32'(rd0_ack), 32'(!exp_p));
            if (rd1_ack) q1.push_back(mem[8'h01]);
            if (rd0_ack) q0.push_back(mem[8'h00]);
        end
        rd0_req = 1'b0;
`ifndef ACTION_ARB_RR_EN
        step(n, 1'b0, 1'b1);
        chk("rd1_after_rd0_drops", 32'(n), 32'd3);
        if (rd1_ack) q1.push_back(16'h0101);
`endif
        rd1_req = 1'b0;
        repeat (4) @(posedge clock); #1;

        // Reset mid-read: outputs clear at once, no valid for the lost read
        rd0_addr = 8'h03; rd0_req = 1'b1;
        step(n, 1'b0, 1'b0);
        rd0_req = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0; #1;
        chk("midreset_outputs_zero", 32'(|{wr_ack, rd0_ack, rd1_ack, rd0_valid, rd1_valid,
            rd0_data, rd1_data, ram_write_enable, ram_read_address}), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("no_valid_after_reset", 32'({rd0_valid, rd1_valid}), 32'd0);
        end
        do_read(1'b0, 8'h03, 16'h0005);
        repeat (2) @(posedge clock); #1;
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
